hardware_result_serializer: RTL and testbench
=============================================

# hardware_result_serializer

Parametrised successor to the fixed single-bit result tap on the reducer top level. It captures full-width result words from the reduction core into a DEPTH-entry FIFO and streams each word out LSB-first in LANE-bit beats over a valid/ready handshake, instead of exposing only bit 0. It sits between the core's result bus and the board-facing output pins or debug link.

## Interface
Parameters:
- WIDTH, 130, width of core result word; must be a multiple of LANE
- LANE, 1, bits per output beat; BEATS = WIDTH/LANE
- DEPTH, 4, FIFO entries; power of two, ≥2

Ports:
- system1000  in  1  clock; all logic on rising edge
- system1000_rst  in  1  reset, synchronous, active-high
- core_word  in  WIDTH  result word from core
- core_valid  in  1  single-cycle strobe; core_word valid this cycle; no backpressure to core
- out_data  out  LANE  current beat
- out_valid  out  1  beat available
- out_ready  in  1  sink accepts beat
- out_last  out  1  high with final beat (beat index BEATS-1) of a word
- fifo_full  out  1  FIFO holds DEPTH words
- dropped  out  1  one-cycle pulse: a word was discarded
- drop_count  out  16  saturating discarded-word count (only with RESULT_SER_DROP_CNT_EN)

## Operation
- FIFO: registered occupancy count. Push when core_valid && !fifo_full. fifo_full derives from the registered count before any same-cycle pop. A push while full is dropped even if a pop occurs that cycle.
- Drop: core_valid while full → dropped = 1 on the next cycle. Word is discarded; FIFO contents are unchanged.
- FSM states:
  - IDLE: out_valid = 0. If the FIFO is non-empty, pop the head into the shift register, set beat = 0, go to SHIFT.
  - SHIFT: out_valid = 1, out_data = shreg[LANE-1:0], out_last = (beat == BEATS-1).
    - On out_valid && out_ready, not last: shift right by LANE, beat++.
    - On accepted last beat: if FIFO non-empty, pop and reload in the same cycle (no bubble, beat = 0). Otherwise go to IDLE.
- Ordering: LSB-first, so beat 0 carries core_word[LANE-1:0]. With LANE = 1 the first beat equals the legacy bit-0 output.
- Stall: out_data and out_last are held stable while out_valid && !out_ready. Once asserted, out_valid does not drop until the last beat is accepted.
- Width rules: the beat counter is clog2(BEATS) bits, minimum 1. The FIFO count is clog2(DEPTH)+1 bits.
- Reset (any cycle, including mid-word): FIFO emptied, FSM to IDLE, shreg and beat cleared, partial word discarded. core_valid is ignored during reset.
- Reset values: out_data = 0, out_valid = 0, out_last = 0, fifo_full = 0, dropped = 0, drop_count = 0.

## Timing
- All outputs are registered or decoded from registers. There is no combinational path from out_ready or core_valid to any output.
- Latency: core_valid at cycle t into an empty FIFO with FSM in IDLE → out_valid = 1 at t+2 with beat 0.
- Throughput: one beat per cycle while out_ready = 1. Back-to-back words have zero idle cycles between them.
- fifo_full updates the cycle after the push or pop that changes it.
- Simultaneous push and pop on a non-full FIFO: both take effect, and the count is unchanged.

## Configuration
- RESULT_SER_DROP_CNT_EN defined: drop_count port and its 16-bit counter are present. The counter increments on each dropped pulse, saturates at 0xFFFF, and clears only on reset.
- Undefined: no drop_count port and no counter. The dropped pulse is still present. All other behaviour is identical.

## Test plan
Bench parameters: WIDTH=8, LANE=2, DEPTH=2, RESULT_SER_DROP_CNT_EN defined.
- Single word: core_word = 0xB4, out_ready held 1 → out_valid from t+2 with beats 0,1,3,2; out_last on the 4th beat; out_valid = 0 the following cycle.
- Stall: same word, out_ready = 0 for 3 cycles at beat 1 → out_data holds 1 and out_valid holds 1 for those cycles; sequence resumes unchanged.
- Back-to-back: push 0x01 then 0xFF with out_ready = 1 → 8 consecutive valid beats 1,0,0,0,3,3,3,3; out_last on beats 4 and 8; no gap.
- Overflow: out_ready = 0; push 0x11, 0x22, 0x33, 0x44 on consecutive cycles → fifo_full = 1; 0x44 dropped (dropped pulses once, drop_count = 1); releasing out_ready streams 0x11, 0x22, 0x33 only.
- Push while full with simultaneous pop → push dropped, count unchanged.
- Mid-word reset: assert system1000_rst for 1 cycle at beat 2 → next cycle out_valid = 0, FIFO empty, drop_count = 0. A new word afterwards streams from beat 0.

Source files
------------

// File: rtl/hardware_result_serializer_if.sv
// rtl/hardware_result_serializer_if.sv - result serializer port bundle
// Purpose: groups the core-side capture signals and the beat-stream side
//   of hardware_result_serializer into one interface.
// Signals:
//   core_word  [WIDTH] result word from the reduction core
//   core_valid         single-cycle strobe, no backpressure to the core
//   out_data   [LANE]  current beat, LSB-first slice of the word
//   out_valid          beat available
//   out_ready          sink accepts beat
//   out_last           final beat of a word
//   fifo_full          capture FIFO holds DEPTH words
//   dropped            one-cycle pulse for a discarded word
//   drop_count [16]    saturating drop counter (RESULT_SER_DROP_CNT_EN only)
// Modports: master = serializer side, slave = core/sink environment side.
interface hardware_result_serializer_if #(
  parameter int WIDTH = 130,
  parameter int LANE  = 1
);
  logic [WIDTH-1:0] core_word;
  logic             core_valid;
  logic [LANE-1:0]  out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             fifo_full;
  logic             dropped;
`ifdef RESULT_SER_DROP_CNT_EN
  logic [15:0]      drop_count;
`endif

  modport master (
    input  core_word,
    input  core_valid,
    input  out_ready,
    output out_data,
    output out_valid,
    output out_last,
    output fifo_full,
    output dropped
`ifdef RESULT_SER_DROP_CNT_EN
    , output drop_count
`endif
  );

  modport slave (
    output core_word,
    output core_valid,
    output out_ready,
    input  out_data,
    input  out_valid,
    input  out_last,
    input  fifo_full,
    input  dropped
`ifdef RESULT_SER_DROP_CNT_EN
    , input drop_count
`endif
  );
endinterface

// File: rtl/hardware_result_serializer.sv
// rtl/hardware_result_serializer.sv - captures core result words and streams them LSB-first in LANE-bit beats
// Purpose: DEPTH-entry FIFO in front of a shift-register serializer with a
//   valid/ready output handshake and a drop indication for overflow.
// Ports:
//   system1000      clock, rising edge
//   system1000_rst  synchronous active-high reset
//   bus             hardware_result_serializer_if.master (core capture side
//                   and beat-stream side, see the interface file)
// Optional feature macro: RESULT_SER_DROP_CNT_EN adds the 16-bit saturating
//   drop_count counter and port.
module hardware_result_serializer #(
  parameter int WIDTH = 130,
  parameter int LANE  = 1,
  parameter int DEPTH = 4
) (
  input  logic                          system1000,
  input  logic                          system1000_rst,
  hardware_result_serializer_if.master  bus
);

  localparam int BEATS = WIDTH / LANE;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = AW + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  typedef enum logic [0:0] {IDLE, SHIFT} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [BW-1:0]    beat_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             dropped_q;

  logic full;
  logic empty;
  logic is_last;
  logic push;
  logic pop;

  // Full is taken from the registered count, so a pop in the same cycle
  // never makes room for a push.
  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign is_last = (beat_q == LAST_BEAT);
  assign push    = bus.core_valid && !full;

  always_comb begin
    pop = 1'b0;
    if (!empty) begin
      if (state_q == IDLE) begin
        pop = 1'b1;
      end else if (bus.out_ready && is_last) begin
        // Reload on the accepted last beat keeps back-to-back words gapless.
        pop = 1'b1;
      end
    end
  end

  // Storage array needs no reset: occupancy is tracked by count_q.
  always_ff @(posedge system1000) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.core_word;
    end
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      beat_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dropped_q <= 1'b0;
    end else begin
      dropped_q <= bus.core_valid && full;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + CW'(push) - CW'(pop);

      case (state_q)
        IDLE: begin
          if (pop) begin
            shreg_q <= mem_q[rd_ptr_q];
            beat_q  <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.out_ready) begin
            if (!is_last) begin
              shreg_q <= shreg_q >> LANE;
              beat_q  <= beat_q + BW'(1);
            end else if (pop) begin
              shreg_q <= mem_q[rd_ptr_q];
              beat_q  <= '0;
            end else begin
              // Clear so out_data idles at zero, matching the reset value.
              shreg_q <= '0;
              beat_q  <= '0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = (state_q == SHIFT);
  assign bus.out_data  = shreg_q[LANE-1:0];
  assign bus.out_last  = (state_q == SHIFT) && is_last;
  assign bus.fifo_full = full;
  assign bus.dropped   = dropped_q;

`ifdef RESULT_SER_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      drop_cnt_q <= '0;
    end else if (dropped_q && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign bus.drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_hardware_result_serializer.sv
// tb/tb_hardware_result_serializer.sv - directed vector bench for hardware_result_serializer
module tb_hardware_result_serializer;

  logic clk;
  logic rst;

  hardware_result_serializer_if #(.WIDTH(8), .LANE(2)) bus ();

  hardware_result_serializer #(
    .WIDTH(8),
    .LANE (2),
    .DEPTH(2)
  ) dut (
    .system1000    (clk),
    .system1000_rst(rst),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       cv;
    logic [7:0] word;
    logic       rdy;
    logic       ev;
    logic [1:0] ed;
    logic       el;
    logic       ef;
    logic       edr;
    logic       cdc;
    logic [15:0] edc;
  } vec_t;

  vec_t vecs[$];
  int   pass_cnt;
  int   total_cnt;

  function automatic void add(input logic r, input logic cv, input logic [7:0] w,
                              input logic rdy, input logic ev, input logic [1:0] ed,
                              input logic el, input logic ef, input logic edr,
                              input logic cdc, input logic [15:0] edc);
    vec_t v;
    v.rst = r; v.cv = cv; v.word = w; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.el = el; v.ef = ef; v.edr = edr;
    v.cdc = cdc; v.edc = edc;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic cv, input logic [7:0] w, input logic rdy);
    rst            = r;
    bus.core_valid = cv;
    bus.core_word  = w;
    bus.out_ready  = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] got_word;
    int         lat;
    pass_cnt  = 0;
    total_cnt = 0;

    // Single word 0xB4 -> beats 0,1,3,2
    add(1,0,8'h00,1, 0,0,0,0,0, 0,0);
    add(0,1,8'hB4,1, 0,0,0,0,0, 0,0);
    add(0,0,8'h00,1, 1,0,0,0,0, 0,0);
    add(0,0,8'h00,1, 1,1,0,0,0, 0,0);
    add(0,0,8'h00,1, 1,3,0,0,0, 0,0);
    add(0,0,8'h00,1, 1,2,1,0,0, 0,0);
    add(0,0,8'h00,1, 0,0,0,0,0, 0,0);
    // Stall 3 cycles at beat 1
    add(1,0,8'h00,1, 0,0,0,0,0, 0,0);
    add(0,1,8'hB4,1, 0,0,0,0,0, 0,0);
    add(0,0,8'h00,1, 1,0,0,0,0, 0,0);
    add(0,0,8'h00,1, 1,1,0,0,0, 0,0);
    add(0,0,8'h00,0, 1,1,0,0,0, 0,0);
    add(0,0,8'h00,0, 1,1,0,0,0, 0,0);
    add(0,0,8'h00,0, 1,1,0,0,0, 0,0);
    add(0,0,8'h00,1, 1,3,0,0,0, 0,0);
    add(0,0,8'h00,1, 1,2,1,0,0, 0,0);
    add(0,0,8'h00,1, 0,0,0,0,0, 0,0);
    // Back-to-back 0x01 then 0xFF
    add(1,0,8'h00,1, 0,0,0,0,0, 0,0);
    add(0,1,8'h01,1, 0,0,0,0,0, 0,0);
    add(0,1,8'hFF,1, 1,1,0,0,0, 0,0);
    add(0,0,8'h00,1, 1,0,0,0,0, 0,0);
    add(0,0,8'h00,1, 1,0,0,0,0, 0,0);
    add(0,0,8'h00,1, 1,0,1,0,0, 0,0);
    add(0,0,8'h00,1, 1,3,0,0,0, 0,0);
    add(0,0,8'h00,1, 1,3,0,0,0, 0,0);
    add(0,0,8'h00,1, 1,3,0,0,0, 0,0);
    add(0,0,8'h00,1, 1,3,1,0,0, 0,0);
    add(0,0,8'h00,1, 0,0,0,0,0, 0,0);
    // Overflow: 0x44 dropped, stream 0x11 0x22 0x33
    add(1,0,8'h00,0, 0,0,0,0,0, 0,0);
    add(0,1,8'h11,0, 0,0,0,0,0, 0,0);
    add(0,1,8'h22,0, 1,1,0,0,0, 0,0);
    add(0,1,8'h33,0, 1,1,0,1,0, 0,0);
    add(0,1,8'h44,0, 1,1,0,1,1, 0,0);
    add(0,0,8'h00,0, 1,1,0,1,0, 0,0);
    add(0,0,8'h00,1, 1,0,0,1,0, 0,0);
    add(0,0,8'h00,1, 1,1,0,1,0, 0,0);
    add(0,0,8'h00,1, 1,0,1,1,0, 0,0);
    add(0,0,8'h00,1, 1,2,0,0,0, 0,0);
    add(0,0,8'h00,1, 1,0,0,0,0, 0,0);
    add(0,0,8'h00,1, 1,2,0,0,0, 0,0);
    add(0,0,8'h00,1, 1,0,1,0,0, 0,0);
    add(0,0,8'h00,1, 1,3,0,0,0, 0,0);
    add(0,0,8'h00,1, 1,0,0,0,0, 0,0);
    add(0,0,8'h00,1, 1,3,0,0,0, 0,0);
    add(0,0,8'h00,1, 1,0,1,0,0, 0,0);
    add(0,0,8'h00,1, 0,0,0,0,0, 1,1);
    // Push while full with simultaneous pop: 0x55 dropped
    add(1,0,8'h00,0, 0,0,0,0,0, 1,0);
    add(0,1,8'h11,0, 0,0,0,0,0, 0,0);
    add(0,1,8'h22,0, 1,1,0,0,0, 0,0);
    add(0,1,8'h33,0, 1,1,0,1,0, 0,0);
    add(0,0,8'h00,1, 1,0,0,1,0, 0,0);
    add(0,0,8'h00,1, 1,1,0,1,0, 0,0);
    add(0,0,8'h00,1, 1,0,1,1,0, 0,0);
    add(0,1,8'h55,1, 1,2,0,0,1, 0,0);
    add(0,0,8'h00,1, 1,0,0,0,0, 0,0);
    add(0,0,8'h00,1, 1,2,0,0,0, 0,0);
    add(0,0,8'h00,1, 1,0,1,0,0, 0,0);
    add(0,0,8'h00,1, 1,3,0,0,0, 0,0);
    add(0,0,8'h00,1, 1,0,0,0,0, 0,0);
    add(0,0,8'h00,1, 1,3,0,0,0, 0,0);
    add(0,0,8'h00,1, 1,0,1,0,0, 0,0);
    add(0,0,8'h00,1, 0,0,0,0,0, 1,1);
    // Mid-word reset at beat 2; core_valid during reset is ignored
    add(0,1,8'hB4,1, 0,0,0,0,0, 0,0);
    add(0,0,8'h00,1, 1,0,0,0,0, 0,0);
    add(0,0,8'h00,1, 1,1,0,0,0, 0,0);
    add(0,0,8'h00,1, 1,3,0,0,0, 0,0);
    add(1,1,8'hFF,1, 0,0,0,0,0, 1,0);
    add(0,0,8'h00,1, 0,0,0,0,0, 1,0);
    add(0,0,8'h00,1, 0,0,0,0,0, 0,0);
    add(0,1,8'h01,1, 0,0,0,0,0, 0,0);
    add(0,0,8'h00,1, 1,1,0,0,0, 0,0);
    add(0,0,8'h00,1, 1,0,0,0,0, 0,0);
    add(0,0,8'h00,1, 1,0,0,0,0, 0,0);
    add(0,0,8'h00,1, 1,0,1,0,0, 0,0);
    add(0,0,8'h00,1, 0,0,0,0,0, 0,0);

    // Reset state
    drive(1, 0, 8'h00, 0);
    tick();
    tick();
    check("reset out_data",  32'(bus.out_data),  32'd0);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset out_last",  32'(bus.out_last),  32'd0);
    check("reset fifo_full", 32'(bus.fifo_full), 32'd0);
    check("reset dropped",   32'(bus.dropped),   32'd0);
`ifdef RESULT_SER_DROP_CNT_EN
    check("reset drop_count", 32'(bus.drop_count), 32'd0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].cv, vecs[i].word, vecs[i].rdy);
      tick();
      check($sformatf("row%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].ev));
      check($sformatf("row%0d out_last", i),  32'(bus.out_last),  32'(vecs[i].el));
      check($sformatf("row%0d fifo_full", i), 32'(bus.fifo_full), 32'(vecs[i].ef));
      check($sformatf("row%0d dropped", i),   32'(bus.dropped),   32'(vecs[i].edr));
      if (vecs[i].ev) begin
        check($sformatf("row%0d out_data", i), 32'(bus.out_data), 32'(vecs[i].ed));
      end
`ifdef RESULT_SER_DROP_CNT_EN
      if (vecs[i].cdc) begin
        check($sformatf("row%0d drop_count", i), 32'(bus.drop_count), 32'(vecs[i].edc));
      end
`endif
    end

    // Latency and word reassembly: 0xC6 -> beats 2,1,0,3
    drive(1, 0, 8'h00, 1);
    tick();
    drive(0, 1, 8'hC6, 1);
    tick();
    drive(0, 0, 8'h00, 1);
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check("latency cycles", 32'(lat), 32'd2);
    got_word = 8'h00;
    for (int b = 0; b < 4; b++) begin
      check($sformatf("reassembly beat%0d valid", b), 32'(bus.out_valid), 32'd1);
      check($sformatf("reassembly beat%0d last", b), 32'(bus.out_last), 32'(b == 3));
      got_word[b*2 +: 2] = bus.out_data;
      tick();
    end
    check("reassembled word", 32'(got_word), 32'hC6);
    check("valid after word", 32'(bus.out_valid), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
